// File: rtl/crc16_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc16_checker
// Function : Serial CRC-16 (reflected x^16+x^12+x^5+1, init 0) frame checker
//            with registered verdict pulse and saturating error counter.
// Revision : 1.0
// ============================================================================
module crc16_checker #(
    parameter int Remainder_Width = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Data_in,
    input  logic       Start,
    input  logic       CRC_in,
    input  logic       CRC_valid,
    output logic       Busy,
    output logic       Check_Done,
    output logic       CRC_Pass,
    output logic       CRC_Fail,
    output logic       Short_Frame,
    output logic [7:0] Err_Count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_CHECK  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_CRC_BIT = 5'd15;

    state_t                     r_state, w_state_nxt;
    logic [Remainder_Width-1:0] r_rem, w_rem_nxt, w_rem_crc;
    logic [4:0]                 r_cnt, w_cnt_nxt;
    logic                       w_done, w_pass, w_fail, w_short, w_busy;

    function automatic logic [Remainder_Width-1:0] crc_step(
        input logic [Remainder_Width-1:0] r,
        input logic                       d
    );
        logic                       fb;
        logic [Remainder_Width-1:0] n;
        fb    = d ^ r[0];
        n     = {fb, r[Remainder_Width-1:1]};
        n[10] = r[11] ^ fb;
        n[3]  = r[4] ^ fb;
        return n;
    endfunction

    assign w_rem_crc = crc_step(r_rem, CRC_in);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_short     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rem_nxt = '0;
                w_cnt_nxt = '0;
                if (Start) begin
                    w_rem_nxt   = crc_step('0, Data_in);
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // Start has priority: a colliding bit is message data
                if (Start) begin
                    w_rem_nxt = crc_step(r_rem, Data_in);
                end else if (CRC_valid) begin
                    w_rem_nxt   = w_rem_crc;
                    w_cnt_nxt   = 5'd1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (Start || !CRC_valid) begin
                    w_state_nxt = S_REPORT;
                    w_done      = 1'b1;
                    w_fail      = 1'b1;
                    w_short     = 1'b1;
                end else begin
                    w_rem_nxt = w_rem_crc;
                    w_cnt_nxt = r_cnt + 5'd1;
                    if (r_cnt == c_LAST_CRC_BIT) begin
                        w_state_nxt = S_REPORT;
                        w_done      = 1'b1;
                        w_pass      = (w_rem_crc == '0);
                        w_fail      = (w_rem_crc != '0);
                    end
                end
            end
            S_REPORT: begin
                w_rem_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
                if (Start) begin
                    w_rem_nxt   = crc_step('0, Data_in);
                    w_state_nxt = S_DATA;
                end
            end
            default: begin
                w_rem_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy = (w_state_nxt == S_DATA) || (w_state_nxt == S_CHECK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_cnt       <= '0;
            Busy        <= 1'b0;
            Check_Done  <= 1'b0;
            CRC_Pass    <= 1'b0;
            CRC_Fail    <= 1'b0;
            Short_Frame <= 1'b0;
            Err_Count   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_cnt       <= w_cnt_nxt;
            Busy        <= w_busy;
            Check_Done  <= w_done;
            CRC_Pass    <= w_pass;
            CRC_Fail    <= w_fail;
            Short_Frame <= w_short;
            // Counter updates with the verdict so it is current during REPORT
            if (w_fail && (Err_Count != 8'hFF)) begin
                Err_Count <= Err_Count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc16_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc16_checker
// Function : Scoreboard bench for crc16_checker using directed frames.
// Revision : 1.0
// ============================================================================
module tb_crc16_checker;

    logic       clk;
    logic       reset_n;
    logic       Data_in, Start, CRC_in, CRC_valid;
    logic       Busy, Check_Done, CRC_Pass, CRC_Fail, Short_Frame;
    logic [7:0] Err_Count;

    crc16_checker #(.Remainder_Width(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Data_in     (Data_in),
        .Start       (Start),
        .CRC_in      (CRC_in),
        .CRC_valid   (CRC_valid),
        .Busy        (Busy),
        .Check_Done  (Check_Done),
        .CRC_Pass    (CRC_Pass),
        .CRC_Fail    (CRC_Fail),
        .Short_Frame (Short_Frame),
        .Err_Count   (Err_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pass;
        logic       fail;
        logic       short_f;
        logic [7:0] err;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] err_model = 8'd0;

    // "123456789", each byte sent LSB first; its CRC is 0x2189
    logic [7:0]  msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                             8'h36, 8'h37, 8'h38, 8'h39};
    logic [15:0] good_crc = 16'h2189;
    logic [15:0] bad_crc  = 16'h2188;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops an expectation for every verdict pulse
    always @(negedge clk) begin
        if (reset_n) begin
            if (Check_Done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Check_Done=1 expected no verdict (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("verdict_cycle", cyc, e.cyc);
                    chk("crc_pass", int'(CRC_Pass), int'(e.pass));
                    chk("crc_fail", int'(CRC_Fail), int'(e.fail));
                    chk("short_frame", int'(Short_Frame), int'(e.short_f));
                    chk("err_count", int'(Err_Count), int'(e.err));
                end
            end else begin
                chk("idle_flags", int'({CRC_Pass, CRC_Fail, Short_Frame}), 0);
            end
        end
    end

    task automatic send_bit(input logic s, input logic d, input logic cv, input logic ci);
        Start = s; Data_in = d; CRC_valid = cv; CRC_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Verdict is expected right after the next clock edge
    task automatic push_exp(input logic p, input logic f, input logic s);
        exp_t e;
        if (f && err_model != 8'hFF) err_model = err_model + 8'd1;
        e.pass = p; e.fail = f; e.short_f = s; e.err = err_model; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // ncrc < 16 truncates the CRC field after ncrc bits
    task automatic send_frame(input logic flip, input logic [15:0] crc, input logic exp_pass,
                              input int ncrc, input logic collide, input logic dgap);
        logic b;
        for (int k = 0; k < 72; k++) begin
            b = msg[k / 8][k % 8];
            if (k == 0 && flip) b = ~b;
            if (dgap && k == 40) idle(3);
            send_bit(1'b1, b, collide && (k == 20), 1'b1);
        end
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == ncrc) begin
                push_exp(1'b0, 1'b1, 1'b1);
                send_bit(1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (i == 15) push_exp(exp_pass, !exp_pass, 1'b0);
            send_bit(1'b0, 1'b0, 1'b1, crc[i]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        Start = 1'b0; Data_in = 1'b0; CRC_valid = 1'b0; CRC_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Check_Done), 0);
        chk("rst_err", int'(Err_Count), 0);
        reset_n = 1'b1;
        idle(2);

        // CRC_valid alone in IDLE is ignored
        send_bit(1'b0, 1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_crc_ignored_busy", int'(Busy), 0);
        idle(2);

        // Good frame
        send_frame(1'b0, good_crc, 1'b1, 16, 1'b0, 1'b0);
        chk("report_busy", int'(Busy), 0);
        idle(3);

        // Flipped first message bit
        send_frame(1'b1, good_crc, 1'b0, 16, 1'b0, 1'b0);
        idle(3);

        // Truncated CRC field after 10 bits
        send_frame(1'b0, good_crc, 1'b1, 10, 1'b0, 1'b0);
        idle(3);

        // Wrong CRC value, with a gap inside the message
        send_frame(1'b0, bad_crc, 1'b0, 16, 1'b0, 1'b1);
        idle(2);

        // Colliding Start/CRC_valid bit counts as data
        send_frame(1'b0, good_crc, 1'b1, 16, 1'b1, 1'b0);
        idle(2);

        // Back-to-back frames: second starts in the REPORT cycle
        send_frame(1'b0, good_crc, 1'b1, 16, 1'b0, 1'b0);
        send_frame(1'b0, good_crc, 1'b1, 16, 1'b0, 1'b0);
        idle(3);

        // 256 aborted frames drive the error counter into saturation
        for (int n = 0; n < 256; n++) begin
            send_bit(1'b1, 1'b1, 1'b0, 1'b0);
            chk("busy_data", int'(Busy), 1);
            send_bit(1'b0, 1'b0, 1'b1, 1'b0);
            push_exp(1'b0, 1'b1, 1'b1);
            send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        chk("err_saturated", int'(Err_Count), 255);

        // Reset during CHECK discards the frame
        for (int k = 0; k < 72; k++) send_bit(1'b1, msg[k / 8][k % 8], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 1'b1, good_crc[i]);
        chk("busy_check", int'(Busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(Busy), 0);
        chk("async_rst_err", int'(Err_Count), 0);
        chk("async_rst_done", int'(Check_Done), 0);
        err_model = 8'd0;
        Start = 1'b0; CRC_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        idle(2);
        send_frame(1'b0, good_crc, 1'b1, 16, 1'b0, 1'b0);
        idle(4);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
